// File: rtl/calc_pkg.sv
// Shared types and constants for the sequential calculator core.
//   op_t           : latched arithmetic operation
//   state_t        : control FSM states (OFF, IDLE, CALC)
//   CALC_W_DEFAULT : default operand/result magnitude width
package calc_pkg;

  localparam int CALC_W_DEFAULT = 7;

  typedef enum logic [1:0] {
    OP_ADD,
    OP_SUB,
    OP_MUL,
    OP_DIV
  } op_t;

  typedef enum logic [1:0] {
    OFF,
    IDLE,
    CALC
  } state_t;

endpackage

// File: rtl/calculadora_seq_if.sv
// Operand, push-button and result bundle between the board top and the
// calculator core.
//   master : board side, drives operands and raw buttons, reads results
//   slave  : calculator core, reads operands/buttons, drives results
//   A, B          operands (W bits, unsigned)
//   b_lig         power toggle button (raw)
//   b_soma/b_sub/b_multi/b_div  operation buttons (raw, active-high)
//   Y, sinal, ovf, err          result magnitude, sign, overflow, div-by-zero
//   EN, busy, done              power-on, iteration running, result pulse
interface calculadora_seq_if #(
  parameter int W = calc_pkg::CALC_W_DEFAULT
);
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         b_lig;
  logic         b_soma;
  logic         b_sub;
  logic         b_multi;
  logic         b_div;
  logic [W-1:0] Y;
  logic         sinal;
  logic         ovf;
  logic         err;
  logic         EN;
  logic         busy;
  logic         done;

  modport master (
    output A, B, b_lig, b_soma, b_sub, b_multi, b_div,
    input  Y, sinal, ovf, err, EN, busy, done
  );

  modport slave (
    input  A, B, b_lig, b_soma, b_sub, b_multi, b_div,
    output Y, sinal, ovf, err, EN, busy, done
  );

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchroniser followed by a rising-edge detector for one raw
// push-button level.
//   clk, rst : clock, asynchronous active-high reset
//   d        : raw button level
//   pulse    : one-cycle event, high two cycles after d is first sampled high
// All flops reset to 1 so a button held through reset yields no event until
// it has been released and pressed again.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);

  logic sync_p0;
  logic sync_p1;
  logic hist_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      hist_p2 <= 1'b1;
    end else begin
      // stage 0: metastability capture
      sync_p0 <= d;
      // stage 1: synchronised level
      sync_p1 <= sync_p0;
      // stage 2: previous level for edge detection
      hist_p2 <= sync_p1;
    end
  end

  assign pulse = sync_p1 & ~hist_p2;

endmodule

// File: rtl/calculadora_seq.sv
// Sequential calculator core. Add/subtract complete in one cycle after a
// command is accepted; multiply (shift-add) and divide (restoring) iterate
// one bit per cycle for W cycles.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : calculadora_seq_if.slave (operands, raw buttons, results)
module calculadora_seq
  import calc_pkg::*;
#(
  parameter int W = CALC_W_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  calculadora_seq_if.slave bus
);

  localparam int CW = $clog2(W + 1);

  // {carry, sum}
  function automatic logic [W:0] add_op(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // {sign, magnitude}
  function automatic logic [W:0] sub_op(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a >= b) return {1'b0, a - b};
    else        return {1'b1, b - a};
  endfunction

  // One shift-add step: the upper W+1 bits accumulate the multiplicand when
  // the current multiplier bit (p[0]) is set, then everything shifts right.
  function automatic logic [2*W:0] mul_step(input logic [2*W:0] p, input logic [W-1:0] a);
    logic [W:0] s;
    s = p[2*W:W] + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
    return {s, p[W-1:0]} >> 1;
  endfunction

  // One restoring-division step, returns {remainder, quotient/dividend}.
  // The trial remainder is below 2*B, so the restored value fits in W bits.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem, input logic [W-1:0] quo,
                                              input logic [W-1:0] b);
    logic [W:0]   r_sh;
    logic [W-1:0] rem_n;
    logic         qbit;
    r_sh = {rem, quo[W-1]};
    if (r_sh >= {1'b0, b}) begin
      rem_n = r_sh[W-1:0] - b;
      qbit  = 1'b1;
    end else begin
      rem_n = r_sh[W-1:0];
      qbit  = 1'b0;
    end
    return {rem_n, quo[W-2:0], qbit};
  endfunction

  logic ev_lig, ev_soma, ev_sub, ev_mul, ev_div;

  sync_edge u_se_lig  (.clk(clk), .rst(rst), .d(bus.b_lig),   .pulse(ev_lig));
  sync_edge u_se_soma (.clk(clk), .rst(rst), .d(bus.b_soma),  .pulse(ev_soma));
  sync_edge u_se_sub  (.clk(clk), .rst(rst), .d(bus.b_sub),   .pulse(ev_sub));
  sync_edge u_se_mul  (.clk(clk), .rst(rst), .d(bus.b_multi), .pulse(ev_mul));
  sync_edge u_se_div  (.clk(clk), .rst(rst), .d(bus.b_div),   .pulse(ev_div));

  state_t         state, state_n;
  op_t            op_n, op_q;
  logic           accept;
  logic           go_off;
  logic           last;
  logic [CW-1:0]  cnt;

  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W:0]   p;
  logic [2*W:0]   p_next;
  logic [W-1:0]   rem;
  logic [W-1:0]   quo;
  logic [2*W-1:0] d_next;

  logic [W-1:0]   y_q;
  logic           sinal_q, ovf_q, err_q, done_q;

  logic [W:0]     add_r;
  logic [W:0]     sub_r;

  assign last   = (cnt == CW'(1));
  assign p_next = mul_step(p, a_q);
  assign d_next = div_step(rem, quo, b_q);
  assign add_r  = add_op(bus.A, bus.B);
  assign sub_r  = sub_op(bus.A, bus.B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OFF;
    else     state <= state_n;
  end

  // Button priority: lig > soma > sub > multi > div. Operation events
  // outside IDLE are dropped.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    go_off  = 1'b0;
    op_n    = OP_ADD;
    case (state)
      OFF: begin
        if (ev_lig) state_n = IDLE;
      end
      IDLE: begin
        if (ev_lig) begin
          state_n = OFF;
          go_off  = 1'b1;
        end else if (ev_soma) begin
          accept = 1'b1;
          op_n   = OP_ADD;
        end else if (ev_sub) begin
          accept = 1'b1;
          op_n   = OP_SUB;
        end else if (ev_mul) begin
          accept  = 1'b1;
          op_n    = OP_MUL;
          state_n = CALC;
        end else if (ev_div) begin
          accept = 1'b1;
          op_n   = OP_DIV;
          // Division by zero is flagged immediately, without iterating.
          if (bus.B != '0) state_n = CALC;
        end
      end
      CALC: begin
        if (ev_lig) begin
          state_n = OFF;
          go_off  = 1'b1;
        end else if (last) begin
          state_n = IDLE;
        end
      end
      default: state_n = OFF;
    endcase
  end

  // Iteration datapath; its contents only matter while CALC is active.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= op_n;
      p    <= {{(W+1){1'b0}}, bus.B};
      rem  <= '0;
      quo  <= bus.A;
    end else if (state == CALC) begin
      p   <= p_next;
      rem <= d_next[2*W-1:W];
      quo <= d_next[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      y_q     <= '0;
      sinal_q <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (go_off) begin
        cnt     <= '0;
        y_q     <= '0;
        sinal_q <= 1'b0;
        ovf_q   <= 1'b0;
        err_q   <= 1'b0;
      end else if (accept) begin
        ovf_q <= 1'b0;
        err_q <= 1'b0;
        case (op_n)
          OP_ADD: begin
            y_q     <= add_r[W-1:0];
            ovf_q   <= add_r[W];
            sinal_q <= 1'b0;
            done_q  <= 1'b1;
          end
          OP_SUB: begin
            y_q     <= sub_r[W-1:0];
            sinal_q <= sub_r[W];
            done_q  <= 1'b1;
          end
          OP_MUL: cnt <= CW'(W);
          default: begin
            if (bus.B == '0) begin
              err_q   <= 1'b1;
              y_q     <= '1;
              sinal_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt <= CW'(W);
            end
          end
        endcase
      end else if (state == CALC) begin
        cnt <= cnt - CW'(1);
        if (last) begin
          done_q  <= 1'b1;
          sinal_q <= 1'b0;
          if (op_q == OP_MUL) begin
            y_q   <= p_next[W-1:0];
            ovf_q <= |p_next[2*W-1:W];
          end else begin
            y_q <= d_next[W-1:0];
          end
        end
      end
    end
  end

  assign bus.Y     = y_q;
  assign bus.sinal = sinal_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_q;
  assign bus.done  = done_q;
  assign bus.EN    = (state != OFF);
  assign bus.busy  = (state == CALC);

endmodule

// File: tb/tb_calculadora_seq.sv
// Directed testbench for calculadora_seq with W = 7.
module tb_calculadora_seq;

  localparam int W = 7;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  calculadora_seq_if #(.W(W)) bus ();

  calculadora_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int i, input logic v);
    case (i)
      0: bus.b_lig   = v;
      1: bus.b_soma  = v;
      2: bus.b_sub   = v;
      3: bus.b_multi = v;
      default: bus.b_div = v;
    endcase
  endtask

  // Short press; on return the internal event is visible (acceptance cycle).
  task automatic press(input int i);
    set_btn(i, 1'b1);
    tick();
    set_btn(i, 1'b0);
    tick();
  endtask

  initial begin
    int nb;
    int nd;
    checks   = 0;
    failures = 0;
    rst         = 1'b1;
    bus.A       = '0;
    bus.B       = '0;
    bus.b_lig   = 1'b0;
    bus.b_soma  = 1'b0;
    bus.b_sub   = 1'b0;
    bus.b_multi = 1'b0;
    bus.b_div   = 1'b0;
    tick();
    tick();
    chk("rst_en",   bus.EN,   0);
    chk("rst_y",    bus.Y,    0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    rst = 1'b0;
    tick();

    // power on
    press(0);
    chk("pwr_en_T", bus.EN, 0);
    tick();
    chk("pwr_en_T1", bus.EN, 1);

    // add in range
    bus.A = 7'd100; bus.B = 7'd27;
    press(1);
    chk("add_done_T", bus.done, 0);
    tick();
    chk("add_y",     bus.Y,     127);
    chk("add_ovf",   bus.ovf,   0);
    chk("add_sinal", bus.sinal, 0);
    chk("add_done",  bus.done,  1);
    tick();
    chk("add_done_pulse", bus.done, 0);
    chk("add_y_hold",     bus.Y,    127);

    // add overflow
    bus.A = 7'd100; bus.B = 7'd28;
    press(1);
    tick();
    chk("addov_y",   bus.Y,   0);
    chk("addov_ovf", bus.ovf, 1);

    // subtract, negative result
    bus.A = 7'd5; bus.B = 7'd9;
    press(2);
    tick();
    chk("sub_y",     bus.Y,     4);
    chk("sub_sinal", bus.sinal, 1);
    chk("sub_ovf",   bus.ovf,   0);

    // multiply with overflow: 12*11 = 132 -> low bits 4
    bus.A = 7'd12; bus.B = 7'd11;
    press(3);
    for (int i = 0; i < 8; i++) tick();
    chk("mulov_y",   bus.Y,   4);
    chk("mulov_ovf", bus.ovf, 1);
    chk("mulov_done", bus.done, 1);

    // multiply 12*10 with operands changing during CALC
    bus.A = 7'd12; bus.B = 7'd10;
    press(3);
    nb = 0; nd = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 0) begin
        chk("mul_ovf_clr", bus.ovf, 0);
        bus.A = 7'd0; bus.B = 7'd127;
      end
      nb += int'(bus.busy);
      nd += int'(bus.done);
    end
    chk("mul_busy_cycles", nb, 7);
    chk("mul_done_early",  nd, 0);
    tick();
    chk("mul_y",    bus.Y,    120);
    chk("mul_ovf",  bus.ovf,  0);
    chk("mul_done", bus.done, 1);
    chk("mul_busy", bus.busy, 0);
    chk("mul_en",   bus.EN,   1);

    // divide 100/7 with a soma press dropped during CALC
    bus.A = 7'd100; bus.B = 7'd7;
    press(4);
    tick();
    chk("div_busy", bus.busy, 1);
    nd = 0;
    press(1);
    nd += int'(bus.done);
    for (int i = 0; i < 4; i++) begin
      tick();
      nd += int'(bus.done);
    end
    chk("div_done_early", nd, 0);
    tick();
    chk("div_y",    bus.Y,    14);
    chk("div_done", bus.done, 1);
    tick();
    tick();
    chk("div_no_extra_done", bus.done, 0);
    chk("div_y_hold",        bus.Y,    14);

    // divide by zero
    bus.A = 7'd100; bus.B = 7'd0;
    press(4);
    tick();
    chk("dz_err",  bus.err,  1);
    chk("dz_y",    bus.Y,    127);
    chk("dz_done", bus.done, 1);
    chk("dz_busy", bus.busy, 0);

    // next add clears err
    bus.A = 7'd1; bus.B = 7'd1;
    press(1);
    tick();
    chk("err_clr", bus.err, 0);
    chk("add2_y",  bus.Y,   2);

    // abort multiply with lig event at T+3
    bus.A = 7'd12; bus.B = 7'd10;
    press(3);
    tick();
    press(0);
    chk("abort_busy_T3", bus.busy, 1);
    tick();
    chk("abort_en",   bus.EN,   0);
    chk("abort_y",    bus.Y,    0);
    chk("abort_busy", bus.busy, 0);
    nd = int'(bus.done);
    for (int i = 0; i < 6; i++) begin
      tick();
      nd += int'(bus.done);
    end
    chk("abort_no_done", nd, 0);

    // power on again, leave a non-zero result, then reset mid-divide
    press(0);
    tick();
    chk("pwr2_en", bus.EN, 1);
    bus.A = 7'd3; bus.B = 7'd4;
    press(1);
    tick();
    chk("add3_y", bus.Y, 7);
    bus.A = 7'd100; bus.B = 7'd7;
    press(4);
    tick();
    tick();
    chk("rdiv_busy", bus.busy, 1);
    #2;
    rst = 1'b1;
    bus.b_soma = 1'b1;
    #1;
    chk("arst_y",    bus.Y,    0);
    chk("arst_en",   bus.EN,   0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    tick();
    rst = 1'b0;
    tick();

    // soma held through reset: no event while held
    press(0);
    tick();
    chk("pwr3_en", bus.EN, 1);
    bus.A = 7'd1; bus.B = 7'd1;
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nd += int'(bus.done);
    end
    chk("held_no_done", nd, 0);
    chk("held_y",       bus.Y, 0);
    bus.b_soma = 1'b0;
    tick();
    tick();
    tick();
    press(1);
    tick();
    chk("rel_done", bus.done, 1);
    chk("rel_y",    bus.Y,    2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calculadora_seq.md
# calculadora_seq

Parametrised sequential calculator core that replaces the fixed 7-bit combinational arithmetic path behind the board top. It takes two unsigned W-bit operands, synchronises and edge-detects the push-button commands on `clk`, and runs add or subtract in one cycle and multiply or divide iteratively over W cycles. It returns a registered magnitude with sign, overflow and error flags to the existing seven-segment decode stage.

## Interface
- `W`, 7: operand and result magnitude width; legal values are 2..16.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `A`  in  W  operand A, unsigned; sampled when a command is accepted.
- `B`  in  W  operand B, unsigned; sampled when a command is accepted.
- `b_lig`  in  1  power button, raw level; each press toggles on/off.
- `b_soma`, `b_sub`, `b_multi`, `b_div`  in  1 each  operation buttons, raw level, active-high.
- `Y`  out  W  result magnitude.
- `sinal`  out  1  result sign, 1 = negative.
- `ovf`  out  1  result exceeded W bits.
- `err`  out  1  division by zero.
- `EN`  out  1  calculator on; the display decoders blank when this is 0.
- `busy`  out  1  iterative operation in progress.
- `done`  out  1  one-cycle pulse when a new result is loaded into `Y`.

## Operation
- Button inputs:
  - Each button passes through a 2-flop synchroniser, then a rising-edge detector.
  - The synchroniser and the edge-history flops reset to 1, so a button held through reset produces no event until it has been released and pressed again.
- States: OFF, IDLE, CALC.
  - OFF → IDLE on a `b_lig` event.
  - IDLE → OFF on a `b_lig` event.
  - CALC → OFF on a `b_lig` event; this aborts the operation and clears all result outputs.
- Command acceptance:
  - Commands are accepted only in IDLE.
  - Priority when several events occur in the same cycle: lig > soma > sub > multi > div.
  - Operation events in OFF or CALC are dropped; they are not queued.
- Acceptance (cycle T): latch A, B and the opcode. Clear `ovf` and `err`.
- Add:
  - The sum is W+1 bits wide.
  - `Y` = sum[W-1:0], `ovf` = sum[W], `sinal` = 0.
- Subtract:
  - If A ≥ B: `Y` = A−B, `sinal` = 0.
  - Otherwise: `Y` = B−A, `sinal` = 1.
  - `ovf` = 0.
- Multiply:
  - Shift-add, one multiplier bit per cycle, W iterations, into a 2W-bit accumulator.
  - `Y` = product[W-1:0], `ovf` = OR of product[2W-1:W].
- Divide:
  - Restoring division, one quotient bit per cycle, W iterations; `Y` = quotient. The remainder is discarded.
  - If B = 0: no iteration. `err` = 1 and `Y` = all ones.
- Register hold:
  - `Y`, `sinal`, `ovf` and `err` hold until the next `done` or until OFF.
  - In OFF all four read 0.

## Timing
- Reset values: state = OFF; `EN`, `Y`, `sinal`, `ovf`, `err`, `busy` and `done` are all 0.
- Button latency: a raw press first sampled high at cycle k produces an internal event at k+2.
- Add, subtract, and divide by zero: results registered and `done` = 1 at T+1. The state stays IDLE.
- Multiply and divide:
  - State is CALC and `busy` = 1 for cycles T+1 … T+W.
  - Result is registered, `done` = 1, `busy` = 0 and state = IDLE at T+W+1.
  - A new command can be accepted from T+W+1 onward.
- `EN` follows the state: it is 1 in IDLE and CALC, registered, and changes in the same cycle as the state.
- A `b_lig` event during CALC at cycle t: state = OFF at t+1 and no `done` pulse.
- Asynchronous `rst` mid-operation: all outputs return to their reset values immediately. The core comes back in OFF.
- `A` and `B` may change freely during CALC without affecting the result.

## Structure
- Package `calc_pkg` holds:
  - the `op_t` enum: OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the `state_t` enum: OFF, IDLE, CALC;
  - the default-width constant.
- Sub-module `sync_edge`: a 2-flop synchroniser plus rising-edge pulse with a reset value of 1. It is instantiated five times, once per button.
- The iteration counter is ⌈log2(W+1)⌉ bits.
- Seven-segment decoding stays outside this block.

## Test plan
All scenarios use W = 7 and start after power-on via `b_lig`.
- Add in range: A=100, B=27, `b_soma` → `Y`=127, `ovf`=0, `sinal`=0, `done` at T+1.
- Add overflow: A=100, B=28, `b_soma` → `Y`=0, `ovf`=1.
- Subtract: A=5, B=9, `b_sub` → `Y`=4, `sinal`=1.
- Multiply:
  - A=12, B=10, `b_multi` → `busy` high for 7 cycles, then `Y`=120, `ovf`=0 at T+8.
  - A=12, B=11 → `Y`=4, `ovf`=1.
- Divide:
  - A=100, B=7, `b_div` → `Y`=14 at T+8.
  - A=100, B=0 → `err`=1, `Y`=127 at T+1.
  - `b_soma` pressed during CALC → ignored; the divide result is unaffected.
- Abort and reset:
  - `b_lig` event at T+3 of a multiply → `EN`=0 and `Y`=0 at T+4, no `done`.
  - `rst` asserted mid-divide → all outputs 0 immediately.
  - A button held through reset → no event until it is released and pressed again.
